// File: rtl/obstacle_spawner.sv
// Obstacle release scheduler: a seeded Galois LFSR picks the gap (in moveClk ticks)
// and sprite type; releases are gated by game state and the current obstacle's busy flag.
module obstacle_spawner #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NUM_TYPES = 6,
    parameter int          MIN_GAP   = 60,
    parameter logic [9:0]  GAP_MASK  = 10'h03F,
    parameter int          GAP_STEP  = 6,
    parameter int          GAP_FLOOR = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       moveClk,
    input  logic [1:0] gameState,
    input  logic [2:0] speed_level,
    input  logic       obs_busy,
    output logic       obs_release,
    output logic [3:0] obs_sel,
    output logic [7:0] spawn_count,
    output logic       armed
);
    localparam logic [15:0]        SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0]        TAPS      = 16'hB400;
    localparam logic [3:0]         NT        = 4'(NUM_TYPES);
    localparam logic signed [10:0] MIN_GAP_S = 11'(MIN_GAP);
    localparam logic signed [10:0] STEP_S    = 11'(GAP_STEP);
    localparam logic signed [10:0] FLOOR_S   = 11'(GAP_FLOOR);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_ARMED   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] shifted;
        shifted   = {1'b0, v[15:1]};
        lfsr_step = v[0] ? (shifted ^ TAPS) : shifted;
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [9:0]         gap_cnt_q, gap_cnt_d;
    logic [3:0]         next_sel_q, next_sel_d;
    logic [3:0]         obs_sel_q, obs_sel_d;
    logic [7:0]         count_q, count_d;
    logic               release_q, release_d;
    logic               armed_q, armed_d;
    logic [1:0]         sync_q, sync_d;
    logic               mv_prev_q, mv_prev_d;
    logic               tick_q, tick_d;

    logic [3:0]         type_s;
    logic [3:0]         sel_s;
    logic signed [10:0] mg_s;
    logic [9:0]         mg_clamp_s;
    logic [9:0]         gap_s;

    // Sprite type and gap length derived from the current LFSR value and speed
    always_comb begin
        type_s = {1'b0, lfsr_q[2:0]};
        if (type_s >= NT) begin
            sel_s = type_s - NT;
        end else begin
            sel_s = type_s;
        end
        mg_s = MIN_GAP_S - ($signed({8'd0, speed_level}) * STEP_S);
        if (mg_s < FLOOR_S) begin
            mg_clamp_s = FLOOR_S[9:0];
        end else begin
            mg_clamp_s = mg_s[9:0];
        end
        gap_s = mg_clamp_s + (lfsr_q[9:0] & GAP_MASK);
    end

    // Next-state logic; outputs are computed from the next state so they register cleanly
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_step(lfsr_q);
        gap_cnt_d  = gap_cnt_q;
        next_sel_d = next_sel_q;
        obs_sel_d  = obs_sel_q;
        count_d    = count_q;
        sync_d     = {sync_q[0], moveClk};
        mv_prev_d  = sync_q[1];
        tick_d     = sync_q[1] & ~mv_prev_q;
        if (gameState != 2'd1) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_LOAD;
                    count_d = 8'd0;
                end
                S_LOAD: begin
                    gap_cnt_d  = gap_s;
                    next_sel_d = sel_s;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (gap_cnt_q == 10'd0) begin
                        state_d = S_ARMED;
                    end else if (tick_q) begin
                        gap_cnt_d = gap_cnt_q - 10'd1;
                    end else begin
                        gap_cnt_d = gap_cnt_q;
                    end
                end
                S_ARMED: begin
                    if (!obs_busy) begin
                        state_d   = S_RELEASE;
                        obs_sel_d = next_sel_q;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end else begin
                            count_d = count_q;
                        end
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_RELEASE: begin
                    state_d = S_LOAD;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        release_d = (state_d == S_RELEASE);
        armed_d   = (state_d == S_ARMED);
    end

    // State, timer, synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED_EFF;
            gap_cnt_q  <= 10'd0;
            next_sel_q <= 4'd0;
            obs_sel_q  <= 4'd0;
            count_q    <= 8'd0;
            release_q  <= 1'b0;
            armed_q    <= 1'b0;
            sync_q     <= 2'd0;
            mv_prev_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            gap_cnt_q  <= gap_cnt_d;
            next_sel_q <= next_sel_d;
            obs_sel_q  <= obs_sel_d;
            count_q    <= count_d;
            release_q  <= release_d;
            armed_q    <= armed_d;
            sync_q     <= sync_d;
            mv_prev_q  <= mv_prev_d;
            tick_q     <= tick_d;
        end
    end

    assign obs_release = release_q;
    assign obs_sel     = obs_sel_q;
    assign spawn_count = count_q;
    assign armed       = armed_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench for obstacle_spawner: a timestamp model predicts every release
// (cycle, sprite type, count); a negedge monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_obstacle_spawner;
    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       moveClk     = 1'b0;
    logic [1:0] gameState   = 2'd0;
    logic [2:0] speed_level = 3'd0;
    logic       obs_busy    = 1'b0;
    logic       obs_release;
    logic [3:0] obs_sel;
    logic [7:0] spawn_count;
    logic       armed;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_rel    = 0;
    int         mv_half  = 4;
    logic [7:0] seen     = 8'd0;

    typedef struct {
        int cyc;
        int sel;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    obstacle_spawner dut (
        .clk         (clk),
        .rst         (rst),
        .moveClk     (moveClk),
        .gameState   (gameState),
        .speed_level (speed_level),
        .obs_busy    (obs_busy),
        .obs_release (obs_release),
        .obs_sel     (obs_sel),
        .spawn_count (spawn_count),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        logic [15:0] r;
        fb = l[0];
        r  = l >> 1;
        if (fb) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int gap_of(input logic [15:0] l, input logic [2:0] spd);
        int mg;
        mg = 60 - int'(spd) * 6;
        if (mg < 24) mg = 24;
        return mg + int'(l[9:0] & 10'h03F);
    endfunction

    function automatic int sel_of(input logic [15:0] l);
        return int'(l[2:0]) % 6;
    endfunction

    // Reference model: samples inputs at each rising edge and predicts release cycles.
    initial begin : model
        logic [15:0] m_lfsr;
        logic [3:0]  h;
        logic        tick;
        bit          idle;
        int          load_c, g, seen_t, arm_c, cnt, sel;
        m_lfsr = 16'hACE1; h = 4'd0; idle = 1'b1;
        load_c = -1; g = 0; seen_t = 0; arm_c = -1; cnt = 0; sel = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_lfsr = 16'hACE1; h = 4'd0; idle = 1'b1;
                load_c = -1; arm_c = -1; cnt = 0;
                exp_q.delete();
            end else begin
                tick = h[2] & ~h[3];
                if (idle) begin
                    if (gameState == 2'd1) begin
                        idle = 1'b0; load_c = cyc + 1; cnt = 0; arm_c = -1;
                    end
                end else if (gameState != 2'd1) begin
                    idle = 1'b1; arm_c = -1;
                end else if (cyc == load_c) begin
                    g = gap_of(m_lfsr, speed_level); sel = sel_of(m_lfsr);
                    seen_t = 0; arm_c = -1;
                end else if (arm_c < 0) begin
                    if (cyc > load_c && tick) begin
                        seen_t++;
                        if (seen_t == g) arm_c = cyc + 2;
                    end
                end else if (cyc >= arm_c && !obs_busy) begin
                    if (cnt < 255) cnt++;
                    exp_q.push_back('{cyc + 1, sel, cnt});
                    load_c = cyc + 2;
                    arm_c  = -1;
                end
                m_lfsr = lfsr_next(m_lfsr);
                h = {h[2:0], moveClk};
            end
            cyc++;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT releases or a release is overdue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (obs_release) begin
                    n_rel++;
                    seen[obs_sel[2:0]] = 1'b1;
                    if (obs_sel > 4'd7) seen[7] = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_release", int'(obs_release), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("release_cycle", cyc, e.cyc);
                        check("release_sel", int'(obs_sel), e.sel);
                        check("release_count", int'(spawn_count), e.cnt);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    check("missed_release", int'(obs_release), 1);
                    e = exp_q.pop_front();
                end
            end
        end
    end

    // moveClk square wave, half-period in clk cycles
    initial begin
        forever begin
            repeat (mv_half) @(negedge clk);
            moveClk = ~moveClk;
        end
    end

    task automatic wait_rel(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && n_rel < target; i++) @(negedge clk);
        check("release_wait", int'(n_rel >= target), 1);
    endtask

    task automatic wait_armed(input int max_cyc);
        for (int i = 0; i < max_cyc && !armed; i++) @(negedge clk);
        check("armed_set", int'(armed), 1);
    endtask

    initial begin : stim
        int r0, armed_cnt, rel_cnt;
        logic [3:0] sv_sel;
        logic [7:0] sv_cnt;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_release", int'(obs_release), 0);
        check("reset_armed", int'(armed), 0);
        check("reset_sel", int'(obs_sel), 0);
        check("reset_count", int'(spawn_count), 0);
        rst = 1'b1;

        // Idle game: nothing may be released
        r0 = n_rel;
        repeat (100) @(negedge clk);
        check("idle_no_release", n_rel - r0, 0);
        check("idle_armed", int'(armed), 0);

        // Running at speed 0, moveClk period 8 clk
        gameState = 2'd1;
        wait_rel(n_rel + 3, 5000);

        // Busy gating: hold the gap expiry off for 50 clk, then let it go
        obs_busy = 1'b1;
        wait_armed(3000);
        armed_cnt = 0;
        rel_cnt   = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (armed) armed_cnt++;
            if (obs_release) rel_cnt++;
        end
        check("busy_armed_hold", armed_cnt, 50);
        check("busy_no_release", rel_cnt, 0);
        obs_busy = 1'b0;
        @(negedge clk);
        check("busy_drop_release", int'(obs_release), 1);
        check("busy_drop_armed", int'(armed), 0);

        // Abort while armed: back to idle, nothing released, type held
        obs_busy = 1'b1;
        wait_armed(3000);
        sv_sel = obs_sel;
        sv_cnt = spawn_count;
        gameState = 2'd2;
        @(negedge clk);
        check("abort_armed", int'(armed), 0);
        check("abort_release", int'(obs_release), 0);
        check("abort_sel", int'(obs_sel), int'(sv_sel));
        check("abort_count_held", int'(spawn_count), int'(sv_cnt));
        gameState = 2'd1;
        @(negedge clk);
        check("rerun_count_clear", int'(spawn_count), 0);
        obs_busy = 1'b0;

        // Fast ticks at speed 7 (floor-clamped gap) until the counter saturates
        speed_level = 3'd7;
        mv_half     = 1;
        wait_rel(n_rel + 300, 60000);
        check("count_saturated", int'(spawn_count), 255);
        check("types_seen", int'(seen), 8'h3F);

        // Reset mid-WAIT clears every output at once
        wait_rel(n_rel + 1, 2000);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_release", int'(obs_release), 0);
        check("midrst_armed", int'(armed), 0);
        check("midrst_sel", int'(obs_sel), 0);
        check("midrst_count", int'(spawn_count), 0);
        gameState = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        r0 = n_rel;
        repeat (100) @(negedge clk);
        check("post_reset_no_release", n_rel - r0, 0);
        check("post_reset_count", int'(spawn_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
